// File: rtl/golomb_result_reporter.sv
// Buffers rulers from the search and streams them to the host as byte frames.
// Define GOLOMB_REPORT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module golomb_result_reporter #(
  parameter int NUMPOSITIONS = 5,
  parameter int VALUE_WIDTH  = 9,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                    clock,
  input  logic                                    RESET,
  input  logic [(NUMPOSITIONS+1)*VALUE_WIDTH-1:0] marks_in,
  input  logic                                    result_strobe,
  input  logic                                    search_done,
  output logic [7:0]                              tx_data,
  output logic                                    tx_valid,
  input  logic                                    tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]             fifo_count,
  output logic                                    overflow,
  output logic                                    report_done
);

  localparam int NM = NUMPOSITIONS + 1;
  localparam int MW = NM * VALUE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NB = 2 * NM;
  localparam int IW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TYPE,
    PAYLOAD,
`ifdef GOLOMB_REPORT_CHECKSUM_EN
    CHK,
`endif
    SUMMARY,
    FIN
  } state_t;

  state_t        state, state_d;
  logic [MW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [MW-1:0] frame, frame_d;
  logic [IW-1:0] idx, idx_d, last;
  logic          is_sum, is_sum_d;
  logic [7:0]    drop_cnt, seen_cnt;
  logic [7:0]    drop_lat, seen_lat;
  logic [7:0]    byte_d;
  logic          valid_d;
  logic          xfer, pop, start_sum;
  logic          take, full, wr;
  logic [MW-1:0] sel;
  logic [15:0]   mark;
`ifdef GOLOMB_REPORT_CHECKSUM_EN
  logic [7:0]    chk, chk_d;
`endif

  // Once the summary frame has begun, later rulers can never be reported.
  assign take = result_strobe && !is_sum && (state != FIN);
  assign full = fifo_count == (AW+1)'(FIFO_DEPTH);
  assign wr   = take && (!full || pop);

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    is_sum_d  = is_sum;
    frame_d   = frame;
    pop       = 1'b0;
    start_sum = 1'b0;
    xfer      = tx_valid && tx_ready;
    last      = is_sum ? IW'(1) : IW'(NB - 1);
`ifdef GOLOMB_REPORT_CHECKSUM_EN
    chk_d = chk;
    if (xfer && (state == TYPE || state == PAYLOAD))
      chk_d = chk ^ tx_data;
`endif
    unique case (state)
      IDLE: begin
        idx_d = '0;
`ifdef GOLOMB_REPORT_CHECKSUM_EN
        chk_d = '0;
`endif
        // A strobe this cycle is not in the FIFO yet; wait so it precedes the summary.
        if (fifo_count != '0) begin
          pop      = 1'b1;
          frame_d  = mem[rd_ptr];
          is_sum_d = 1'b0;
          state_d  = HDR;
        end else if (search_done && !result_strobe) begin
          start_sum = 1'b1;
          is_sum_d  = 1'b1;
          state_d   = HDR;
        end
      end
      HDR: if (xfer) state_d = TYPE;
      TYPE: begin
        if (xfer) begin
          state_d = PAYLOAD;
          idx_d   = '0;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (idx == last)
`ifdef GOLOMB_REPORT_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = is_sum ? FIN : IDLE;
`endif
          else
            idx_d = idx + 1'b1;
        end
      end
`ifdef GOLOMB_REPORT_CHECKSUM_EN
      CHK: if (xfer) state_d = is_sum ? FIN : IDLE;
`endif
      FIN: state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // Output byte is computed from the next state so tx_data/tx_valid can be registered.
  always_comb begin
    sel     = frame_d >> ((NM - 1 - int'(idx_d >> 1)) * VALUE_WIDTH);
    mark    = '0;
    mark[VALUE_WIDTH-1:0] = sel[VALUE_WIDTH-1:0];
    byte_d  = 8'h00;
    valid_d = 1'b0;
    unique case (state_d)
      HDR: begin
        byte_d  = 8'hA5;
        valid_d = 1'b1;
      end
      TYPE: begin
        byte_d  = is_sum_d ? 8'h02 : 8'h01;
        valid_d = 1'b1;
      end
      PAYLOAD: begin
        valid_d = 1'b1;
        if (is_sum_d)
          byte_d = idx_d[0] ? seen_lat : drop_lat;
        else
          byte_d = idx_d[0] ? mark[7:0] : mark[15:8];
      end
`ifdef GOLOMB_REPORT_CHECKSUM_EN
      CHK: begin
        byte_d  = chk_d;
        valid_d = 1'b1;
      end
`endif
      default: begin
        byte_d  = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (RESET) begin
      state       <= IDLE;
      idx         <= '0;
      is_sum      <= 1'b0;
      frame       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      drop_cnt    <= '0;
      seen_cnt    <= '0;
      drop_lat    <= '0;
      seen_lat    <= '0;
      overflow    <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      report_done <= 1'b0;
`ifdef GOLOMB_REPORT_CHECKSUM_EN
      chk         <= '0;
`endif
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      is_sum      <= is_sum_d;
      frame       <= frame_d;
      tx_data     <= byte_d;
      tx_valid    <= valid_d;
      report_done <= state_d == FIN;
`ifdef GOLOMB_REPORT_CHECKSUM_EN
      chk         <= chk_d;
`endif
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !wr)
        fifo_count <= fifo_count - 1'b1;
      if (take && seen_cnt != 8'hFF)
        seen_cnt <= seen_cnt + 1'b1;
      if (take && !wr) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 1'b1;
      end
      if (start_sum) begin
        drop_lat <= drop_cnt;
        seen_lat <= seen_cnt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr)
      mem[wr_ptr] <= marks_in;
  end

endmodule
